// File: rtl/riscv_ckpt_checker.sv
// riscv_ckpt_checker: compares a CPU's retired-instruction count and output port
// against a table of checkpoints, reporting pass, failure cause, or timeout.
module riscv_ckpt_checker #(
   parameter int          NUM_TEST = 40,
   parameter int          IWIDTH   = 6,
   parameter logic [31:0] TIMEOUT  = 32'd1000000
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              CFG_WE,
   input  logic [IWIDTH-1:0] CFG_IDX,
   input  logic [31:0]       CFG_NUM_INST,
   input  logic [31:0]       CFG_ANS,
   input  logic [IWIDTH-1:0] CFG_COUNT,
   input  logic              START,
   input  logic [31:0]       NUM_INST,
   input  logic [31:0]       OUTPUT_PORT,
   input  logic              HALT,
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic [IWIDTH-1:0] PASS_CNT,
   output logic [IWIDTH-1:0] FAIL_IDX,
   output logic [2:0]        FAIL_CODE,
   output logic [31:0]       FAIL_GOT,
   output logic [31:0]       CYCLE
);
   typedef enum logic [1:0] {IDLE, RUN, PASSED, FAILED} state_t;
   state_t            state, state_n;
   logic [31:0]       tbl_ni  [NUM_TEST];
   logic [31:0]       tbl_ans [NUM_TEST];
   logic [IWIDTH-1:0] count, count_n, ptr, ptr_n, fidx_n, ridx;
   logic [2:0]        code_n;
   logic [31:0]       got_n, cycle_n;
   logic              cmp, eq, ok;
   // Table is plain memory: no reset, reloaded by software after every reset.
   always_ff @(posedge CLK)
      if (CFG_WE && state != RUN && 32'(CFG_IDX) < NUM_TEST) begin
         tbl_ni[CFG_IDX]  <= CFG_NUM_INST;
         tbl_ans[CFG_IDX] <= CFG_ANS;
      end
   assign ridx     = (32'(ptr) < NUM_TEST) ? ptr : '0;
   assign cmp      = ptr < count && 32'(ptr) < NUM_TEST;
   assign eq       = NUM_INST == tbl_ni[ridx];
   assign ok       = eq && OUTPUT_PORT == tbl_ans[ridx];
   assign PASS_CNT = ptr;
   always_comb begin
      state_n = state;
      count_n = count;
      ptr_n   = ptr;
      code_n  = FAIL_CODE;
      fidx_n  = FAIL_IDX;
      got_n   = FAIL_GOT;
      cycle_n = CYCLE;
      if (state != RUN) begin
         if (START) begin
            state_n = RUN;
            count_n = CFG_COUNT;
            ptr_n   = '0;
            code_n  = '0;
            fidx_n  = '0;
            got_n   = '0;
            cycle_n = '0;
         end
      end else begin
         cycle_n = CYCLE + 32'd1;
         if (cmp && ok) ptr_n = ptr + IWIDTH'(1);
         // Priority: checkpoint failure, then halt, then timeout.
         if (cmp && eq && !ok) code_n = 3'd1;
         else if (cmp && NUM_INST > tbl_ni[ridx]) code_n = 3'd2;
         else if (HALT) code_n = (ptr_n == count) ? 3'd0 : 3'd3;
         else if (cycle_n == TIMEOUT - 32'd1) code_n = 3'd4;
         if (code_n != 3'd0) begin
            state_n = FAILED;
            fidx_n  = ptr_n;
            got_n   = OUTPUT_PORT;
         end else if (HALT) state_n = PASSED;
      end
   end
   always_ff @(posedge CLK or negedge RSTn)
      if (!RSTn) begin
         state     <= IDLE;
         count     <= '0;
         ptr       <= '0;
         FAIL_CODE <= '0;
         FAIL_IDX  <= '0;
         FAIL_GOT  <= '0;
         CYCLE     <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         PASS      <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         ptr       <= ptr_n;
         FAIL_CODE <= code_n;
         FAIL_IDX  <= fidx_n;
         FAIL_GOT  <= got_n;
         CYCLE     <= cycle_n;
         BUSY      <= state_n == RUN;
         DONE      <= state_n == PASSED || state_n == FAILED;
         PASS      <= state_n == PASSED;
      end
endmodule

// File: tb/tb_riscv_ckpt_checker.sv
// tb_riscv_ckpt_checker: directed vector table plus hand sequences for the
// failure causes, reset, halt/timeout corners and write protection in RUN.
module tb_riscv_ckpt_checker;
   logic        CLK, RSTn, CFG_WE, START, HALT;
   logic [5:0]  CFG_IDX, CFG_COUNT, PASS_CNT, FAIL_IDX;
   logic [31:0] CFG_NUM_INST, CFG_ANS, NUM_INST, OUTPUT_PORT, FAIL_GOT, CYCLE;
   logic        BUSY, DONE, PASS;
   logic [2:0]  FAIL_CODE;
   int          n_cmp = 0, n_bad = 0;
   typedef struct {
      logic [31:0] ni, op;
      logic        h, b, d, p;
      logic [5:0]  cnt;
      logic [2:0]  code;
      logic [31:0] cyc;
   } vec_t;
   vec_t v[10];
   riscv_ckpt_checker #(.NUM_TEST(40), .IWIDTH(6), .TIMEOUT(32'd16)) dut (
      .CLK(CLK), .RSTn(RSTn), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
      .CFG_NUM_INST(CFG_NUM_INST), .CFG_ANS(CFG_ANS), .CFG_COUNT(CFG_COUNT),
      .START(START), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT),
      .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .PASS_CNT(PASS_CNT),
      .FAIL_IDX(FAIL_IDX), .FAIL_CODE(FAIL_CODE), .FAIL_GOT(FAIL_GOT), .CYCLE(CYCLE)
   );
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask
   task automatic res(input string nm, input logic b, input logic d, input logic p,
                      input logic [5:0] cnt, input logic [2:0] code,
                      input logic [5:0] idx, input logic [31:0] got);
      chk({nm, " busy"}, 32'(BUSY), 32'(b));
      chk({nm, " done"}, 32'(DONE), 32'(d));
      chk({nm, " pass"}, 32'(PASS), 32'(p));
      chk({nm, " pass_cnt"}, 32'(PASS_CNT), 32'(cnt));
      chk({nm, " fail_code"}, 32'(FAIL_CODE), 32'(code));
      chk({nm, " fail_idx"}, 32'(FAIL_IDX), 32'(idx));
      chk({nm, " fail_got"}, FAIL_GOT, got);
   endtask
   task automatic step(input logic [31:0] ni, input logic [31:0] op, input logic h);
      NUM_INST = ni;
      OUTPUT_PORT = op;
      HALT = h;
      @(posedge CLK);
      #1;
      HALT = 1'b0;
   endtask
   task automatic load(input logic [5:0] idx, input logic [31:0] ni, input logic [31:0] ans);
      CFG_WE = 1'b1;
      CFG_IDX = idx;
      CFG_NUM_INST = ni;
      CFG_ANS = ans;
      @(posedge CLK);
      #1;
      CFG_WE = 1'b0;
   endtask
   task automatic start(input logic [5:0] cnt);
      CFG_COUNT = cnt;
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
   endtask
   initial begin
      v[0] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
      v[1] = '{1, 0, 0, 1, 0, 0, 0, 0, 2};
      v[2] = '{2, 0, 0, 1, 0, 0, 0, 0, 3};
      v[3] = '{3, 0, 0, 1, 0, 0, 0, 0, 4};
      v[4] = '{4, 32'h0f00, 0, 1, 0, 0, 1, 0, 5};
      v[5] = '{5, 0, 0, 1, 0, 0, 1, 0, 6};
      v[6] = '{6, 32'h18, 0, 1, 0, 0, 2, 0, 7};
      v[7] = '{7, 0, 1, 0, 1, 1, 2, 0, 8};
      v[8] = '{9, 0, 0, 0, 1, 1, 2, 0, 8};
      v[9] = '{10, 0, 1, 0, 1, 1, 2, 0, 8};
      RSTn = 1'b0; CFG_WE = 1'b0; CFG_IDX = '0; CFG_NUM_INST = '0; CFG_ANS = '0;
      CFG_COUNT = '0; START = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0; HALT = 1'b0;
      #12;
      res("reset", 0, 0, 0, 0, 0, 0, 0);
      chk("reset cycle", CYCLE, 0);
      RSTn = 1'b1;
      @(posedge CLK);
      #1;
      load(0, 4, 32'h0f00);
      load(1, 6, 32'h18);
      start(2);
      res("start", 1, 0, 0, 0, 0, 0, 0);
      chk("start cycle", CYCLE, 0);
      for (int i = 0; i < 10; i++) begin
         step(v[i].ni, v[i].op, v[i].h);
         chk($sformatf("v%0d busy", i), 32'(BUSY), 32'(v[i].b));
         chk($sformatf("v%0d done", i), 32'(DONE), 32'(v[i].d));
         chk($sformatf("v%0d pass", i), 32'(PASS), 32'(v[i].p));
         chk($sformatf("v%0d pass_cnt", i), 32'(PASS_CNT), 32'(v[i].cnt));
         chk($sformatf("v%0d fail_code", i), 32'(FAIL_CODE), 32'(v[i].code));
         chk($sformatf("v%0d cycle", i), CYCLE, v[i].cyc);
      end
      chk("passed fail_idx", 32'(FAIL_IDX), 0);
      chk("passed fail_got", FAIL_GOT, 0);
      // answer mismatch at the second checkpoint
      start(2);
      for (int n = 0; n < 6; n++) step(n, (n == 4) ? 32'h0f00 : 32'h0, 1'b0);
      step(6, 32'h17, 1'b0);
      res("mismatch", 0, 1, 0, 1, 1, 1, 32'h17);
      step(6, 32'h18, 1'b1);
      res("mismatch hold", 0, 1, 0, 1, 1, 1, 32'h17);
      // restart from FAILED clears the failure record; then skip a checkpoint
      start(2);
      res("restart", 1, 0, 0, 0, 0, 0, 0);
      chk("restart cycle", CYCLE, 0);
      step(3, 32'h0, 1'b0);
      step(5, 32'h99, 1'b0);
      res("skipped", 0, 1, 0, 0, 2, 0, 32'h99);
      // early halt with one checkpoint pending
      start(2);
      step(4, 32'h0f00, 1'b0);
      step(5, 32'h5, 1'b1);
      res("early halt", 0, 1, 0, 1, 3, 1, 32'h5);
      // last checkpoint and halt on the same edge
      start(2);
      step(4, 32'h0f00, 1'b0);
      step(6, 32'h18, 1'b1);
      res("match+halt", 0, 1, 1, 2, 0, 0, 0);
      // timeout with TIMEOUT=16
      start(2);
      for (int k = 0; k < 14; k++) step(0, 0, 1'b0);
      res("pre timeout", 1, 0, 0, 0, 0, 0, 0);
      chk("pre timeout cycle", CYCLE, 14);
      step(0, 32'h3, 1'b0);
      res("timeout", 0, 1, 0, 0, 4, 0, 32'h3);
      chk("timeout cycle", CYCLE, 15);
      step(0, 0, 1'b0);
      chk("timeout cycle hold", CYCLE, 15);
      // empty table: no comparison, first halt passes
      start(0);
      step(123, 0, 1'b0);
      res("count0 run", 1, 0, 0, 0, 0, 0, 0);
      step(124, 0, 1'b1);
      res("count0 halt", 0, 1, 1, 0, 0, 0, 0);
      // asynchronous reset mid-run
      start(2);
      step(4, 32'h0f00, 1'b0);
      res("pre reset", 1, 0, 0, 1, 0, 0, 0);
      #2 RSTn = 1'b0;
      #1;
      res("async reset", 0, 0, 0, 0, 0, 0, 0);
      chk("async reset cycle", CYCLE, 0);
      #2 RSTn = 1'b1;
      for (int k = 0; k < 3; k++) step(4, 32'h0f00, 1'b1);
      res("post reset idle", 0, 0, 0, 0, 0, 0, 0);
      chk("post reset cycle", CYCLE, 0);
      // table writes ignored during RUN
      load(0, 4, 32'h0f00);
      load(1, 6, 32'h18);
      NUM_INST = 0;
      start(1);
      load(0, 2, 32'h55);
      step(2, 32'h55, 1'b0);
      res("we in run", 1, 0, 0, 0, 0, 0, 0);
      step(4, 32'h0f00, 1'b0);
      chk("we in run orig match", 32'(PASS_CNT), 1);
      step(5, 0, 1'b1);
      res("we in run halt", 0, 1, 1, 1, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
